multdiv_ctrl: RTL
=================

MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 SHALL have parameter MULT_ITER, default 16: radix-4 Booth iterations per multiply.
REQ-002 SHALL have parameter DIV_ITER, default 32: non-restoring divide iterations per divide.
REQ-003 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port ctrl_MULT  input  1  single-cycle start pulse for a signed multiply.
REQ-006 SHALL have port ctrl_DIV  input  1  single-cycle start pulse for a signed divide.
REQ-007 SHALL have port data_operandA  input  32  multiplicand / dividend, two's complement.
REQ-008 SHALL have port data_operandB  input  32  multiplier / divisor, two's complement.
REQ-009 SHALL have port data_result  output  32  low 32 bits of product, or quotient.
REQ-010 SHALL have port data_exception  output  1  overflow or divide-by-zero flag, valid with data_resultRDY.
REQ-011 SHALL have port data_resultRDY  output  1  one-cycle completion strobe.

Function
REQ-012 SHALL sample ctrl_MULT/ctrl_DIV on every rising edge ("start edge" = edge 0) and latch both operands at that edge.
REQ-013 SHALL implement states IDLE, MULT, DIV, DONE; start edge moves to MULT or DIV from any state, last iteration to DONE, DONE to IDLE after one cycle.
REQ-014 SHALL give ctrl_MULT priority when ctrl_MULT and ctrl_DIV are high on the same edge.
REQ-015 SHALL abort any in-flight operation on a new start edge and restart with the new operands; aborted operation produces no strobe.
REQ-016 SHALL perform one iteration per clock using a 6-bit iteration counter, cleared at the start edge.
REQ-017 SHALL, for multiply, compute the full 64-bit signed product by radix-4 Booth recoding and assert data_resultRDY for exactly the cycle following edge MULT_ITER+1 (edge 17 by default).
REQ-018 SHALL set data_exception on multiply when product bits [63:31] are not all equal (result not representable in signed 32 bits).
REQ-019 SHALL, for divide, compute a signed quotient truncated toward zero and assert data_resultRDY after edge DIV_ITER+1 (edge 33 by default).
REQ-020 SHALL, for divisor 0, skip iteration, drive data_result=0, data_exception=1, data_resultRDY after edge 2.
REQ-021 SHALL, for 0x80000000 / 0xFFFFFFFF, drive data_result=0x80000000 and data_exception=1.
REQ-022 SHALL hold data_result and data_exception stable from the strobe until the next start edge; both are undefined-free (driven) at all times.
REQ-023 SHALL keep data_resultRDY low in IDLE, MULT and DIV, and high only in DONE.

Reset
REQ-024 SHALL on reset force state IDLE, counter 0, data_result 0, data_exception 0, data_resultRDY 0, immediately and independent of clock.
REQ-025 SHALL, on reset mid-operation, discard the operation with no strobe; first start edge after reset deassertion begins normally.

Structure
REQ-026 SHALL place the state enumeration, MULT_ITER/DIV_ITER defaults and counter width in shared package multdiv_pkg.
REQ-027 SHALL instantiate one combinational sub-module booth_recoder mapping 3 multiplier bits to a digit in {-2,-1,0,+1,+2}.
REQ-028 SHALL keep the multiply and divide datapaths sharing one 65-bit accumulator/shift register.

Verification
REQ-029 SHALL test ctrl_MULT with A=6, B=7 -> data_result=42, data_exception=0, data_resultRDY exactly once after edge 17.
REQ-030 SHALL test ctrl_MULT with A=0x40000000, B=4 -> data_result=0x00000000, data_exception=1.
REQ-031 SHALL test ctrl_DIV with A=-7, B=2 -> data_result=0xFFFFFFFD, data_exception=0, strobe after edge 33.
REQ-032 SHALL test ctrl_DIV with A=5, B=0 -> data_result=0, data_exception=1, strobe after edge 2.
REQ-033 SHALL test ctrl_MULT and ctrl_DIV high together with A=3, B=4 -> data_result=12 after edge 17; then reset at edge 8 of a new multiply -> no strobe, outputs 0.
REQ-034 SHALL test a second ctrl_MULT (A=2, B=5) at edge 10 of a running divide -> single strobe after edge 17 relative to the restart, data_result=10.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide controller.
package multdiv_pkg;

  localparam int MULT_ITER_DEF = 16;
  localparam int DIV_ITER_DEF  = 32;
  localparam int CNT_W         = 6;
  localparam int ACC_W         = 65;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/booth_recoder.sv
// Radix-4 Booth recoder: {b[i+1], b[i], b[i-1]} -> signed digit in {-2..+2}.
module booth_recoder (
  input  logic [2:0]        triplet,
  output logic signed [2:0] digit
);

  always_comb begin
    digit = 3'sd0;
    case (triplet)
      3'b001, 3'b010: digit = 3'sd1;
      3'b011:         digit = 3'sd2;
      3'b100:         digit = -3'sd2;
      3'b101, 3'b110: digit = -3'sd1;
      default:        digit = 3'sd0;
    endcase
  end

endmodule

// File: rtl/multdiv_ctrl.sv
// Iterative signed 32-bit multiplier (radix-4 Booth) and divider (non-restoring)
// sharing one 65-bit accumulator; a new start pulse always restarts the unit.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int MULT_ITER = MULT_ITER_DEF,
  parameter int DIV_ITER  = DIV_ITER_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_ITER);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_ITER);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               booth_prev_q, booth_prev_d;
  logic [31:0]        opa_q, opa_d;
  logic [31:0]        opb_q, opb_d;
  logic [31:0]        result_q, result_d;
  logic               exc_q, exc_d;

  // Multiply view: acc = {partial[32:0], remaining multiplier bits[31:0]}.
  logic signed [2:0]  booth_digit;
  logic [34:0]        mcand_ext, booth_addend, booth_sum;
  logic [ACC_W-1:0]   mult_next;
  logic [63:0]        product;
  logic               mult_ovf;

  booth_recoder u_booth (
    .triplet ({acc_q[1], acc_q[0], booth_prev_q}),
    .digit   (booth_digit)
  );

  assign mcand_ext = {{3{opa_q[31]}}, opa_q};

  always_comb begin
    booth_addend = '0;
    case (booth_digit)
      3'b001:  booth_addend = mcand_ext;
      3'b010:  booth_addend = mcand_ext << 1;
      3'b111:  booth_addend = -mcand_ext;
      3'b110:  booth_addend = -(mcand_ext << 1);
      default: booth_addend = '0;
    endcase
  end

  assign booth_sum = {{2{acc_q[64]}}, acc_q[64:32]} + booth_addend;
  assign mult_next = {booth_sum[34:2], booth_sum[1:0], acc_q[31:2]};
  assign product   = acc_q[63:0];
  assign mult_ovf  = !((&product[63:31]) || (~|product[63:31]));

  // Divide view: acc = {signed remainder[32:0], dividend/quotient bits[31:0]},
  // operating on magnitudes and fixing the quotient sign at the end.
  logic [31:0]        a_mag, divisor_mag, quot_signed;
  logic [33:0]        div_shift, div_trial;
  logic [ACC_W-1:0]   div_next;
  logic               div_zero, div_ovf;

  assign a_mag       = data_operandA[31] ? -data_operandA : data_operandA;
  assign divisor_mag = opb_q[31] ? -opb_q : opb_q;
  assign div_shift   = {acc_q[64:32], acc_q[31]};
  assign div_trial   = acc_q[64] ? div_shift + {2'b00, divisor_mag}
                                 : div_shift - {2'b00, divisor_mag};
  assign div_next    = {div_trial[32:0], acc_q[30:0], ~div_trial[33]};
  assign quot_signed = (opa_q[31] ^ opb_q[31]) ? -acc_q[31:0] : acc_q[31:0];
  assign div_zero    = (opb_q == 32'h0000_0000);
  assign div_ovf     = (opa_q == 32'h8000_0000) && (opb_q == 32'hFFFF_FFFF);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    booth_prev_d = booth_prev_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    result_d     = result_q;
    exc_d        = exc_q;

    if (ctrl_MULT || ctrl_DIV) begin
      cnt_d        = '0;
      booth_prev_d = 1'b0;
      opa_d        = data_operandA;
      opb_d        = data_operandB;
      if (ctrl_MULT) begin
        state_d = MULT;
        acc_d   = {33'd0, data_operandB};
      end else begin
        state_d = DIV;
        acc_d   = {33'd0, a_mag};
      end
    end else begin
      case (state_q)
        MULT: begin
          if (cnt_q == MULT_LAST) begin
            result_d = product[31:0];
            exc_d    = mult_ovf;
            state_d  = DONE;
          end else begin
            acc_d        = mult_next;
            booth_prev_d = acc_q[1];
            cnt_d        = cnt_q + 1'b1;
          end
        end
        DIV: begin
          if (cnt_q == DIV_LAST) begin
            result_d = div_zero ? 32'h0000_0000 : quot_signed;
            exc_d    = div_zero || div_ovf;
            state_d  = DONE;
          end else if (div_zero) begin
            cnt_d = DIV_LAST;  // jump straight to the finishing cycle
          end else begin
            acc_d = div_next;
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      booth_prev_q <= 1'b0;
      opa_q        <= '0;
      opb_q        <= '0;
      result_q     <= '0;
      exc_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      booth_prev_q <= booth_prev_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      result_q     <= result_d;
      exc_q        <= exc_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);

endmodule
